// File: rtl/if_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_pkg;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HOLD = 2'd1,
    S_DROP = 2'd2
  } if_state_e;

  localparam logic [31:0] DEFAULT_NOP_INSTR = 32'h0000_0000;
  localparam logic [31:0] PC_INC            = 32'd4;

  function automatic logic [31:0] align_pc(input logic [31:0] pc);
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry buffer for an instruction that arrived while decode was stalled.
module if_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  logic        valid_reg;
  logic [31:0] pc_reg;
  logic [31:0] instr_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      pc_reg    <= '0;
      instr_reg <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      pc_reg    <= load_pc;
      instr_reg <= load_instr;
    end else if (clear) begin
      valid_reg <= 1'b0;
    end
  end

  assign valid = valid_reg;
  assign pc    = pc_reg;
  assign instr = instr_reg;

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: drives a variable-latency instruction memory,
// steers the PC register and loads the IF/ID pipeline register.
module if_stage
  import if_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_q,
  output logic [31:0] pc_next,
  output logic        pc_write,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_pc4,
  output logic [31:0] ifid_instr
);

  if_state_e   state_reg, state_next;
  logic [31:0] drop_addr_reg, drop_addr_next;

  logic        ifid_valid_reg;
  logic [31:0] ifid_pc_reg, ifid_pc4_reg, ifid_instr_reg;

  logic        hold_load, hold_clear, hold_valid;
  logic [31:0] hold_pc, hold_instr;

  logic        deliver;
  logic [31:0] deliver_pc, deliver_instr;
  logic [31:0] redirect_tgt;

  assign redirect_tgt = align_pc(redirect_pc);

  if_hold_buf u_hold_buf (
    .clk        (clk),
    .rst        (rst),
    .load       (hold_load),
    .clear      (hold_clear),
    .load_pc    (pc_q),
    .load_instr (imem_rdata),
    .valid      (hold_valid),
    .pc         (hold_pc),
    .instr      (hold_instr)
  );

  always_comb begin
    state_next     = state_reg;
    drop_addr_next = drop_addr_reg;
    pc_write       = 1'b0;
    pc_next        = pc_q + PC_INC;
    imem_req       = 1'b0;
    imem_addr      = pc_q;
    hold_load      = 1'b0;
    hold_clear     = 1'b0;
    deliver        = 1'b0;
    deliver_pc     = pc_q;
    deliver_instr  = imem_rdata;

    case (state_reg)
      S_REQ: begin
        imem_req = 1'b1;
        if (redirect) begin
          pc_write = 1'b1;
          pc_next  = redirect_tgt;
          if (!imem_ack) begin
            drop_addr_next = pc_q;
            state_next     = S_DROP;
          end
        end else if (imem_ack) begin
          // A flush squashes the word arriving now along with IF/ID.
          pc_write = 1'b1;
          if (!flush) begin
            if (stall) begin
              hold_load  = 1'b1;
              state_next = S_HOLD;
            end else begin
              deliver = 1'b1;
            end
          end
        end
      end

      S_HOLD: begin
        if (redirect) begin
          pc_write   = 1'b1;
          pc_next    = redirect_tgt;
          hold_clear = 1'b1;
          state_next = S_REQ;
        end else if (flush) begin
          hold_clear = 1'b1;
          state_next = S_REQ;
        end else if (!stall) begin
          deliver       = hold_valid;
          deliver_pc    = hold_pc;
          deliver_instr = hold_instr;
          hold_clear    = 1'b1;
          state_next    = S_REQ;
        end
      end

      S_DROP: begin
        // Keep presenting the abandoned address until memory completes it.
        imem_req  = 1'b1;
        imem_addr = drop_addr_reg;
        if (redirect) begin
          pc_write = 1'b1;
          pc_next  = redirect_tgt;
        end
        if (imem_ack) state_next = S_REQ;
      end

      default: state_next = S_REQ;
    endcase

    if (rst) begin
      pc_write = 1'b0;
      imem_req = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= S_REQ;
      drop_addr_reg <= '0;
    end else begin
      state_reg     <= state_next;
      drop_addr_reg <= drop_addr_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ifid_valid_reg <= 1'b0;
      ifid_pc_reg    <= '0;
      ifid_pc4_reg   <= '0;
      ifid_instr_reg <= NOP_INSTR;
    end else if (redirect || flush) begin
      ifid_valid_reg <= 1'b0;
      ifid_instr_reg <= NOP_INSTR;
    end else if (!stall) begin
      ifid_valid_reg <= deliver;
      if (deliver) begin
        ifid_pc_reg    <= deliver_pc;
        ifid_pc4_reg   <= deliver_pc + PC_INC;
        ifid_instr_reg <= deliver_instr;
      end
    end
  end

  assign ifid_valid = ifid_valid_reg;
  assign ifid_pc    = ifid_pc_reg;
  assign ifid_pc4   = ifid_pc4_reg;
  assign ifid_instr = ifid_instr_reg;

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the pipelined MIPS core, sitting between the PC register and the decode stage. Each cycle it:
- reads the current PC;
- issues a request to a variable-latency instruction memory;
- computes the next PC and write-enable fed back to the PC register;
- loads the IF/ID pipeline register.

It absorbs memory wait states, hazard-unit stalls and branch/jump redirects, including a redirect that arrives while a fetch is still outstanding.

## Interface
Parameters:
- NOP_INSTR, 32'h0000_0000, instruction word placed in ifid_instr on reset and flush.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- pc_q  in  32  current PC from PC register
- pc_next  out  32  value for PC register pc_in
- pc_write  out  1  PC register write enable (pcWrite)
- imem_req  out  1  instruction fetch request
- imem_addr  out  32  fetch address
- imem_ack  in  1  fetch data valid this cycle (may be same cycle as req)
- imem_rdata  in  32  fetched instruction
- stall  in  1  hazard unit: hold IF/ID and stop PC advance
- flush  in  1  squash IF/ID contents
- redirect  in  1  branch/jump taken
- redirect_pc  in  32  target; bits [1:0] forced to 00
- ifid_valid  out  1  IF/ID holds a live instruction
- ifid_pc  out  32  PC of IF/ID instruction
- ifid_pc4  out  32  ifid_pc + 4 (mod 2^32)
- ifid_instr  out  32  instruction word

## Operation
- Priority: rst > redirect > flush > stall > normal.
- States: S_REQ (fetch outstanding), S_HOLD (instruction buffered, stalled), S_DROP (discarding a stale fetch).
- Reset values:
  - state = S_REQ
  - ifid_valid = 0, ifid_pc = 0, ifid_pc4 = 0, ifid_instr = NOP_INSTR
  - hold buffer empty
  - pc_write = 0 while rst is high
- S_REQ:
  - imem_req = 1, imem_addr = pc_q.
  - ack & !redirect & !stall: IF/ID <= {1, pc_q, pc_q+4, imem_rdata}; pc_write = 1, pc_next = pc_q+4.
  - ack & !redirect & stall: rdata/pc_q go to the hold buffer; pc_write = 1, pc_next = pc_q+4; go to S_HOLD.
  - ack & redirect: discard rdata; pc_write = 1, pc_next = redirect_pc; stay in S_REQ.
  - !ack & redirect: latch pc_q into drop_addr; pc_write = 1, pc_next = redirect_pc; go to S_DROP.
  - !ack & !redirect: pc_write = 0.
- S_HOLD:
  - imem_req = 0, pc_write = 0.
  - redirect: clear the buffer; pc_write = 1, pc_next = redirect_pc; go to S_REQ.
  - flush: clear the buffer; go to S_REQ.
  - !stall: buffer moves to IF/ID (valid = 1); go to S_REQ.
- S_DROP:
  - imem_req = 1, imem_addr = drop_addr, which stays constant until ack.
  - ack: discard; go to S_REQ.
  - A further redirect while in S_DROP: pc_write = 1, pc_next = redirect_pc; remain in S_DROP.
- IF/ID update rules:
  - redirect or flush: ifid_valid <= 0, ifid_instr <= NOP_INSTR, whether or not stall is asserted.
  - Else stall: IF/ID holds.
  - Else if no instruction delivered this cycle: ifid_valid <= 0 (bubble).
- Memory protocol: once imem_req is raised, imem_addr stays stable until ack.
- Address arithmetic: all +4 operations are 32-bit and wrap (FFFF_FFFC+4 = 0).

## Timing
- pc_next, pc_write, imem_req and imem_addr are combinational from state and inputs (Mealy).
- Zero-wait memory (ack in the cycle of req):
  - One instruction per cycle.
  - IF/ID is valid the cycle after the fetch address appears on pc_q.
- N wait cycles: N bubbles in IF/ID; the PC does not advance until ack.
- Redirect at edge k: pc_q = redirect_pc at k+1, and the first target fetch is issued at k+1 (S_REQ) or after the stale ack (S_DROP).
- Stall release from S_HOLD: the buffered instruction appears in IF/ID one cycle after stall deasserts.
- Reset asserted mid-fetch: the outstanding request is abandoned immediately. The memory must tolerate a dropped req.

## Structure
- Package if_pkg holds:
  - state enum {S_REQ, S_HOLD, S_DROP}
  - default NOP_INSTR constant
  - PC_INC = 32'd4
- Single module. The hold buffer (valid + pc + instr) may optionally be factored into sub-module if_hold_buf.

## Test plan
- Reset then zero-wait memory, pc_q from a PC model at 0: ifid_pc sequence 0, 4, 8 on consecutive cycles, ifid_valid = 1 from cycle 2.
- ack delayed 2 cycles at PC 0x10: two bubbles (ifid_valid = 0), then ifid_pc = 0x10, ifid_pc4 = 0x14; pc_write high only in the ack cycle.
- Stall asserted in the ack cycle of 0x20 for 3 cycles: IF/ID holds its prior value, imem_req = 0; after release ifid_pc = 0x20, then 0x24 is fetched.
- Redirect to 0x103 while 0x40 is outstanding (ack 2 cycles later): state S_DROP, imem_addr = 0x40 until ack, 0x40 data never reaches IF/ID, next ifid_pc = 0x100.
- Flush with stall asserted at the same time: ifid_valid = 0 and ifid_instr = NOP_INSTR next cycle.
- pc_q = 0xFFFF_FFFC, zero-wait: pc_next = 0x0000_0000, ifid_pc4 = 0.
